// File: rtl/bus_mem.sv
// rtl/bus_mem.sv - word-addressed RAM with wait-state read FSM and zero word 0
// Optional BUS_MEM_MMIO_EN maps byte address 16'hFFFC to an 8-bit leds register.
module bus_mem #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic [15:0] i_addr,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic [7:0]  leds
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    cnt;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   pend_data;
    logic [31:0]   word;
    logic [AW-1:0] idx;
    logic          accept;
    logic          is_mmio;
    logic          is_zero;
    logic          unused_addr;

    assign idx         = i_addr[AW+1:2];
    assign is_zero     = (idx == '0);
    assign unused_addr = ^i_addr;
    assign accept      = rd_en && !wr_en && (state == IDLE || state == VALID);

`ifdef BUS_MEM_MMIO_EN
    assign is_mmio = (i_addr == 16'hFFFC);

    always_ff @(posedge clk) begin
        if (rst) begin
            leds <= 8'h00;
        end else if (wr_en && is_mmio) begin
            leds <= wr_data[7:0];
        end
    end
`else
    assign is_mmio = 1'b0;
    assign leds    = 8'h00;
`endif

    // MMIO wins over RAM; index 0 is hardwired to zero regardless of RAM content.
    always_comb begin
        word = mem[idx];
        if (is_mmio) begin
            word = {24'h0, leds};
        end else if (is_zero) begin
            word = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en && !is_mmio && !is_zero) begin
            mem[idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rd_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (WAIT_STATES == 0) ? VALID : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = VALID;
                end
            end
            VALID: begin
                rd_valid = 1'b1;
                if (accept) begin
                    state_next = (WAIT_STATES == 0) ? VALID : WAIT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Data is captured at acceptance so writes during the wait cannot alter it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            pend_data <= 32'h0;
            rd_data   <= 32'h0;
        end else if (accept) begin
            pend_data <= word;
            cnt       <= WS_LOAD;
            if (WAIT_STATES == 0) begin
                rd_data <= word;
            end
        end else if (state == WAIT) begin
            if (cnt == 4'd0) begin
                rd_data <= pend_data;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_bus_mem.sv
// tb/tb_bus_mem.sv - bench for bus_mem, zero-wait and three-wait instances side by side
module tb_bus_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd_data0, rd_data3;
    logic        rd_valid0, rd_valid3;
    logic [7:0]  leds0, leds3;

    int compared   = 0;
    int mismatched = 0;
    bit cmp_en     = 1'b0;

    always #5 clk = ~clk;

    bus_mem #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .rd_en(rd_en), .i_addr(addr), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .wr_en(wr_en), .wr_data(wdata), .leds(leds0)
    );

    bus_mem #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u3 (
        .clk(clk), .rst(rst), .rd_en(rd_en), .i_addr(addr), .rd_data(rd_data3),
        .rd_valid(rd_valid3), .wr_en(wr_en), .wr_data(wdata), .leds(leds3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: each accepted read is scheduled to appear ws edges later.
    int          cyc = 0;
    logic [31:0] mmem     [2][1024];
    logic [7:0]  mleds    [2];
    int          vedge    [2];
    int          next_ok  [2];
    logic [31:0] vdata    [2];
    logic [31:0] exp_data [2];
    logic        exp_valid[2];

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            int          ws;
            int          idx;
            logic        mm;
            logic [31:0] d;
            ws  = (k == 0) ? 0 : 3;
            idx = int'(addr[15:2]) % 1024;
`ifdef BUS_MEM_MMIO_EN
            mm = (addr == 16'hFFFC);
`else
            mm = 1'b0;
`endif
            if (rst) begin
                vedge[k]     = -1;
                next_ok[k]   = 0;
                mleds[k]     = 8'h00;
                exp_valid[k] = 1'b0;
                exp_data[k]  = 32'h0;
            end else begin
                exp_valid[k] = 1'b0;
                if (rd_en && !wr_en && cyc >= next_ok[k]) begin
                    if (mm) d = {24'h0, mleds[k]};
                    else if (idx == 0) d = 32'h0;
                    else d = mmem[k][idx];
                    vdata[k]   = d;
                    vedge[k]   = cyc + ws;
                    next_ok[k] = cyc + ws + 1;
                end
                if (wr_en) begin
                    if (mm) mleds[k] = wdata[7:0];
                    else if (idx != 0) mmem[k][idx] = wdata;
                end
                if (vedge[k] == cyc) begin
                    exp_valid[k] = 1'b1;
                    exp_data[k]  = vdata[k];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("u0_rd_valid", {31'h0, rd_valid0}, {31'h0, exp_valid[0]});
            chk("u0_rd_data", rd_data0, exp_data[0]);
            chk("u0_leds", {24'h0, leds0}, {24'h0, mleds[0]});
            chk("u3_rd_valid", {31'h0, rd_valid3}, {31'h0, exp_valid[1]});
            chk("u3_rd_data", rd_data3, exp_data[1]);
            chk("u3_leds", {24'h0, leds3}, {24'h0, mleds[1]});
        end
    end

    task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rd_en = r;
        wr_en = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 32'h0);
    endtask

    initial begin
        rst   = 1'b1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        addr  = 16'h0;
        wdata = 32'h0;
        step(1'b1, 1'b1, 16'h0040, 32'hFFFF_FFFF);
        cmp_en = 1'b1;
        chk("rst_u0_valid", {31'h0, rd_valid0}, 32'h0);
        chk("rst_u0_data", rd_data0, 32'h0);
        chk("rst_u0_leds", {24'h0, leds0}, 32'h0);
        chk("rst_u3_valid", {31'h0, rd_valid3}, 32'h0);
        chk("rst_u3_data", rd_data3, 32'h0);
        chk("rst_u3_leds", {24'h0, leds3}, 32'h0);
        step(1'b0, 1'b0, 16'h0, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 1024; i++) step(1'b0, 1'b1, 16'(i << 2), 32'hC0DE_0000 | 32'(i));

        step(1'b0, 1'b1, 16'h0080, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 16'h0080, 32'h0);
        step(1'b0, 1'b0, 16'h0, 32'h0);
        chk("wr_rd_u0_valid", {31'h0, rd_valid0}, 32'h1);
        chk("wr_rd_u0_data", rd_data0, 32'hDEAD_BEEF);
        idle(3);
        chk("wr_rd_u3_valid", {31'h0, rd_valid3}, 32'h1);
        chk("wr_rd_u3_data", rd_data3, 32'hDEAD_BEEF);
        idle(2);

        step(1'b0, 1'b1, 16'h0084, 32'h1111_2222);
        step(1'b1, 1'b0, 16'h0080, 32'h0);
        step(1'b1, 1'b0, 16'h0084, 32'h0);
        chk("b2b_first", rd_data0, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 16'h0, 32'h0);
        chk("b2b_second_valid", {31'h0, rd_valid0}, 32'h1);
        chk("b2b_second", rd_data0, 32'h1111_2222);
        idle(5);

        step(1'b1, 1'b0, 16'h0010, 32'h0);
        step(1'b1, 1'b0, 16'h0020, 32'h0);
        chk("ws3_wait1", {31'h0, rd_valid3}, 32'h0);
        step(1'b1, 1'b0, 16'h0024, 32'h0);
        chk("ws3_wait2", {31'h0, rd_valid3}, 32'h0);
        step(1'b1, 1'b0, 16'h0028, 32'h0);
        chk("ws3_wait3", {31'h0, rd_valid3}, 32'h0);
        step(1'b0, 1'b0, 16'h0, 32'h0);
        chk("ws3_valid", {31'h0, rd_valid3}, 32'h1);
        chk("ws3_data", rd_data3, 32'hC0DE_0004);
        idle(5);

        step(1'b0, 1'b1, 16'h0000, 32'h1234_5678);
        step(1'b1, 1'b0, 16'h0000, 32'h0);
        step(1'b0, 1'b0, 16'h0, 32'h0);
        chk("zero_word", rd_data0, 32'h0);
        step(1'b1, 1'b1, 16'h0008, 32'h55AA_55AA);
        step(1'b0, 1'b0, 16'h0, 32'h0);
        chk("rdwr_no_valid", {31'h0, rd_valid0}, 32'h0);
        chk("rdwr_hold", rd_data0, 32'h0);
        step(1'b1, 1'b0, 16'h0008, 32'h0);
        step(1'b0, 1'b0, 16'h0, 32'h0);
        chk("rdwr_written", rd_data0, 32'h55AA_55AA);
        idle(5);

        step(1'b0, 1'b1, 16'h1004, 32'hA5A5_A5A5);
        step(1'b1, 1'b0, 16'h0004, 32'h0);
        step(1'b0, 1'b0, 16'h0, 32'h0);
        chk("wrap", rd_data0, 32'hA5A5_A5A5);
        idle(5);
        step(1'b1, 1'b0, 16'h0010, 32'h0);
        step(1'b0, 1'b0, 16'h0, 32'h0);
        rst = 1'b1;
        step(1'b0, 1'b0, 16'h0, 32'h0);
        rst = 1'b0;
        chk("abort_valid", {31'h0, rd_valid3}, 32'h0);
        chk("abort_leds", {24'h0, leds3}, 32'h0);
        idle(6);

        step(1'b0, 1'b1, 16'hFFFC, 32'h0000_01C3);
        step(1'b1, 1'b0, 16'hFFFC, 32'h0);
`ifdef BUS_MEM_MMIO_EN
        chk("mmio_leds", {24'h0, leds0}, 32'h0000_00C3);
`else
        chk("mmio_leds", {24'h0, leds0}, 32'h0);
`endif
        step(1'b0, 1'b0, 16'h0, 32'h0);
`ifdef BUS_MEM_MMIO_EN
        chk("mmio_read", rd_data0, 32'h0000_00C3);
`else
        chk("mmio_read", rd_data0, 32'h0000_01C3);
`endif
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/bus_mem.md
BUS_MEM -- requirements
Module: bus_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning RAM depth in 32-bit words (power of two, 16..16384).
REQ-002 SHALL have parameter WAIT_STATES, default 0, meaning extra read-latency cycles (0..15).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 rd_en  input  1  read request from initiator.
REQ-007 i_addr  input  16  byte address; bits [1:0] ignored.
REQ-008 rd_data  output  32  read data, meaningful only while rd_valid=1.
REQ-009 rd_valid  output  1  one-cycle read-data-valid strobe.
REQ-010 wr_en  input  1  write request; word written at the sampling edge.
REQ-011 wr_data  input  32  write data.
REQ-012 leds  output  8  memory-mapped output register (see Configuration).

Function
REQ-013 SHALL compute word index = i_addr[15:2] modulo DEPTH_WORDS, so out-of-range addresses wrap.
REQ-014 SHALL implement FSM IDLE, WAIT, VALID; rd_valid=1 only in VALID.
REQ-015 SHALL accept a read at an edge where rd_en=1, wr_en=0, and state is IDLE or VALID.
REQ-016 SHALL capture RAM data for the accepted word at the acceptance edge; later writes do not alter it.
REQ-017 On acceptance with WAIT_STATES=0: next state VALID; otherwise WAIT with counter loaded to WAIT_STATES-1.
REQ-018 In WAIT: counter decrements each edge; at count 0 -> VALID; rd_en/i_addr changes ignored.
REQ-019 VALID lasts exactly one cycle; -> IDLE unless a new read is accepted that edge (back-to-back, per REQ-015/017).
REQ-020 Read latency SHALL be WAIT_STATES+1 cycles from acceptance edge to rd_valid cycle; sustained throughput 1 word/cycle at WAIT_STATES=0.
REQ-021 rd_data SHALL hold its last value outside VALID.
REQ-022 SHALL accept writes in any state; write to word index 0 SHALL be discarded (x0 reads as zero).
REQ-023 rd_en and wr_en both high: write performed, read not accepted, no rd_valid generated.
REQ-024 Write at edge N followed by read accepted at edge N+1 to same word SHALL return the new data.
REQ-025 Word index 0 SHALL always read 32'h0000_0000.

Reset
REQ-026 rst=1 at an edge: state IDLE, counter 0, rd_valid 0, rd_data 0, leds 0.
REQ-027 Reset mid-read (WAIT or VALID) SHALL abort; no rd_valid for that request after reset.
REQ-028 RAM contents SHALL NOT be cleared by reset; rd_en/wr_en ignored while rst=1.

Configuration
REQ-029 Macro BUS_MEM_MMIO_EN defined: i_addr 16'hFFFC is the leds register; write sets leds=wr_data[7:0], read returns {24'h0, leds}; RAM not accessed at that address.
REQ-030 BUS_MEM_MMIO_EN undefined: leds tied 8'h00; 16'hFFFC maps to RAM per REQ-013.

Verification
REQ-031 WAIT_STATES=0: write 0xDEADBEEF @0x0080, then rd_en @0x0080 -> rd_valid 1 cycle later, rd_data=0xDEADBEEF.
REQ-032 WAIT_STATES=0: rd_en held, address 0x0080 then 0x0084 on consecutive edges -> rd_valid two consecutive cycles, data in order.
REQ-033 WAIT_STATES=3: read @0x0010 -> rd_valid exactly 4 cycles after acceptance; address change during WAIT has no effect.
REQ-034 Write 0x12345678 @0x0000, read 0x0000 -> rd_data=0; simultaneous rd_en+wr_en @0x0008 -> word updated, no rd_valid.
REQ-035 DEPTH_WORDS=1024: write 0xA5A5A5A5 @0x1004, read 0x0004 -> 0xA5A5A5A5; rst asserted during WAIT -> no rd_valid, leds=0.
REQ-036 BUS_MEM_MMIO_EN: write 0x000001C3 @0xFFFC -> leds=0xC3, read 0xFFFC -> 0x000000C3; without macro leds stays 0x00.
